// File: rtl/dccm_lsu_if.sv
// Request/response bundle between the execute stage and dccm_lsu.
// master = pipeline side, slave = load/store unit side.
interface dccm_lsu_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int TAG_WIDTH  = 4
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [1:0]            req_size;
   logic                  req_unsigned;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;
   logic [TAG_WIDTH-1:0]  req_tag;
   logic                  rsp_valid;
   logic [31:0]           rsp_data;
   logic [TAG_WIDTH-1:0]  rsp_tag;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned,
      output req_addr, req_wdata, req_tag,
      input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned,
      input  req_addr, req_wdata, req_tag,
      output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
   );
endinterface

// File: rtl/dccm_lsu.sv
// Load/store unit in front of the DCCM: lane extraction on loads,
// read-modify-write for sub-word stores (DCCM has no byte enables).
module dccm_lsu #(
   parameter int  DEPTH      = 1024,
   parameter int  TAG_WIDTH  = 4,
   localparam int ADDR_WIDTH = $clog2(DEPTH) + 2,
   localparam int IW         = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   dccm_lsu_if.slave     bus,
   output logic [IW-1:0] dccm_raddr,
   output logic          dccm_rvalid_in,
   input  logic [31:0]   dccm_rdata,
   input  logic          dccm_rvalid_out,
   output logic [IW-1:0] dccm_waddr,
   output logic          dccm_wen,
   output logic [31:0]   dccm_wdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RMW  = 2'd2;

   logic [1:0]           state;
   logic [1:0]           lane_q;
   logic [1:0]           size_q;
   logic                 uns_q;
   logic [15:0]          wdata_q;
   logic [TAG_WIDTH-1:0] tag_q;
   logic [IW-1:0]        idx_q;

   logic                 rsp_valid_q;
   logic                 rsp_err_q;
   logic [31:0]          rsp_data_q;
   logic [TAG_WIDTH-1:0] rsp_tag_q;

   logic          acc;
   logic          misal;
   logic          is_sw;
   logic [IW-1:0] idx;
   logic [1:0]    lane;
   logic [31:0]   merged;
   logic [31:0]   ld_ext;
   logic [7:0]    ld_b;
   logic [15:0]   ld_h;

   assign idx   = bus.req_addr[ADDR_WIDTH-1:2];
   assign lane  = bus.req_addr[1:0];
   assign is_sw = bus.req_we && (bus.req_size == 2'd2);
   assign misal = (bus.req_size == 2'd3)
               || (bus.req_size == 2'd1 && lane[0])
               || (bus.req_size == 2'd2 && lane != 2'd0);

   // Gated by rst so nothing reaches the DCCM while reset is held.
   assign bus.req_ready = (state == S_IDLE) && !rst;
   assign acc           = bus.req_valid && bus.req_ready;

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_tag   = rsp_tag_q;

   always_comb begin
      merged = dccm_rdata;
      if (size_q == 2'd0) begin
         case (lane_q)
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end else if (lane_q[1]) begin
         merged[31:16] = wdata_q;
      end else begin
         merged[15:0] = wdata_q;
      end
   end

   always_comb begin
      case (lane_q)
         2'd0:    ld_b = dccm_rdata[7:0];
         2'd1:    ld_b = dccm_rdata[15:8];
         2'd2:    ld_b = dccm_rdata[23:16];
         default: ld_b = dccm_rdata[31:24];
      endcase
      ld_h = lane_q[1] ? dccm_rdata[31:16] : dccm_rdata[15:0];
      case (size_q)
         2'd0:    ld_ext = {{24{!uns_q && ld_b[7]}}, ld_b};
         2'd1:    ld_ext = {{16{!uns_q && ld_h[15]}}, ld_h};
         default: ld_ext = dccm_rdata;
      endcase
   end

   always_comb begin
      dccm_rvalid_in = 1'b0;
      dccm_raddr     = '0;
      dccm_wen       = 1'b0;
      dccm_waddr     = '0;
      dccm_wdata     = '0;
      case (state)
         S_IDLE: begin
            if (acc && !misal) begin
               if (is_sw) begin
                  dccm_wen   = 1'b1;
                  dccm_waddr = idx;
                  dccm_wdata = bus.req_wdata;
               end else begin
                  dccm_rvalid_in = 1'b1;
                  dccm_raddr     = idx;
               end
            end
         end
         S_RMW: begin
            if (dccm_rvalid_out) begin
               dccm_wen   = 1'b1;
               dccm_waddr = idx_q;
               dccm_wdata = merged;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         lane_q      <= '0;
         size_q      <= '0;
         uns_q       <= 1'b0;
         wdata_q     <= '0;
         tag_q       <= '0;
         idx_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
         rsp_tag_q   <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (acc) begin
                  lane_q  <= lane;
                  size_q  <= bus.req_size;
                  uns_q   <= bus.req_unsigned;
                  wdata_q <= bus.req_wdata[15:0];
                  tag_q   <= bus.req_tag;
                  idx_q   <= idx;
                  if (misal || is_sw) begin
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= misal;
                     rsp_data_q  <= '0;
                     rsp_tag_q   <= bus.req_tag;
                  end else begin
                     state <= bus.req_we ? S_RMW : S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (dccm_rvalid_out) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_data_q  <= ld_ext;
                  rsp_tag_q   <= tag_q;
                  state       <= S_IDLE;
               end
            end
            S_RMW: begin
               if (dccm_rvalid_out) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_data_q  <= '0;
                  rsp_tag_q   <= tag_q;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dccm_lsu.sv
// Directed bench for dccm_lsu with a behavioural one-cycle-latency DCCM.
module tb_dccm_lsu;
   localparam int DEPTH = 1024;
   localparam int TW    = 4;
   localparam int AW    = 12;
   localparam int IW    = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dccm_lsu_if #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

   logic [IW-1:0] dccm_raddr;
   logic [IW-1:0] dccm_waddr;
   logic          dccm_rvalid_in;
   logic          dccm_rvalid_out;
   logic          dccm_wen;
   logic [31:0]   dccm_rdata;
   logic [31:0]   dccm_wdata;

   logic [31:0]   mem [DEPTH];
   logic          rv_q = 1'b0;
   logic          rv_extra = 1'b0;
   logic          pl_en = 1'b0;
   logic [IW-1:0] pl_addr = '0;
   logic [31:0]   pl_data = '0;
   int            n_rd = 0;
   int            n_wen = 0;
   int            n_cmp = 0;
   int            n_bad = 0;

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (dccm_wen) mem[dccm_waddr] <= dccm_wdata;
      rv_q <= dccm_rvalid_in;
      if (dccm_rvalid_in) dccm_rdata <= mem[dccm_raddr];
      if (dccm_rvalid_in) n_rd <= n_rd + 1;
      if (dccm_wen) n_wen <= n_wen + 1;
   end
   assign dccm_rvalid_out = rv_q | rv_extra;

   dccm_lsu #(.DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave),
      .dccm_raddr(dccm_raddr),
      .dccm_rvalid_in(dccm_rvalid_in),
      .dccm_rdata(dccm_rdata),
      .dccm_rvalid_out(dccm_rvalid_out),
      .dccm_waddr(dccm_waddr),
      .dccm_wen(dccm_wen),
      .dccm_wdata(dccm_wdata)
   );

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic [TW-1:0] t);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = a;
      bus.req_wdata    = wd;
      bus.req_tag      = t;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      n_cmp++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0 ||
          dccm_rvalid_in !== 1'b0 || dccm_wen !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_outs: rsp_valid=%b data=%h rd=%b wen=%b want 0",
                  bus.rsp_valid, bus.rsp_data, dccm_rvalid_in, dccm_wen);
      end
      nxt();
      nxt();
      rst = 1'b0;
      pl_en = 1'b1;
      pl_addr = 10'd4;
      pl_data = 32'h887766F5;
      nxt();
      pl_en = 1'b0;
      n_cmp++;
      if (bus.req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_ready: got %b want 1", bus.req_ready);
      end
   endtask

   task automatic test_loads();
      logic [AW-1:0] va [5] = '{12'h010, 12'h010, 12'h010, 12'h012, 12'h012};
      logic [1:0]    vs [5] = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1};
      logic          vu [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0]   ve [5] = '{32'h887766F5, 32'hFFFFFFF5, 32'h000000F5,
                                32'hFFFF8877, 32'h00008877};
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, vs[i], vu[i], va[i], 32'h0, TW'(i + 3));
         #1;
         n_cmp++;
         if (dccm_rvalid_in !== 1'b1 || dccm_raddr !== 10'd4) begin
            n_bad++;
            $display("FAIL load%0d_strobe: rd=%b raddr=%0d want 1/4",
                     i, dccm_rvalid_in, dccm_raddr);
         end
         nxt();
         bus.req_valid = 1'b0;
         n_cmp++;
         if (bus.rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL load%0d_early: rsp_valid=%b want 0", i, bus.rsp_valid);
         end
         nxt();
         n_cmp++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== ve[i] ||
             bus.rsp_tag !== TW'(i + 3) || bus.rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL load%0d_rsp: v=%b d=%h t=%0d e=%b want 1 %h %0d 0",
                     i, bus.rsp_valid, bus.rsp_data, bus.rsp_tag,
                     bus.rsp_err, ve[i], i + 3);
         end
      end
   endtask

   task automatic test_sb_rmw();
      drive(1'b1, 2'd0, 1'b0, 12'h011, 32'h000000AB, 4'd5);
      #1;
      n_cmp++;
      if (dccm_rvalid_in !== 1'b1 || dccm_raddr !== 10'd4 || dccm_wen !== 1'b0) begin
         n_bad++;
         $display("FAIL sb_read: rd=%b raddr=%0d wen=%b want 1/4/0",
                  dccm_rvalid_in, dccm_raddr, dccm_wen);
      end
      nxt();
      bus.req_valid = 1'b0;
      #1;
      n_cmp++;
      if (dccm_wen !== 1'b1 || dccm_waddr !== 10'd4 || dccm_wdata !== 32'h8877ABF5) begin
         n_bad++;
         $display("FAIL sb_write: wen=%b waddr=%0d wdata=%h want 1/4/8877abf5",
                  dccm_wen, dccm_waddr, dccm_wdata);
      end
      nxt();
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'd5 ||
          bus.rsp_data !== 32'h0 || bus.rsp_err !== 1'b0) begin
         n_bad++;
         $display("FAIL sb_rsp: v=%b t=%0d d=%h e=%b want 1 5 0 0",
                  bus.rsp_valid, bus.rsp_tag, bus.rsp_data, bus.rsp_err);
      end
      drive(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 4'd6);
      nxt();
      bus.req_valid = 1'b0;
      nxt();
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h8877ABF5) begin
         n_bad++;
         $display("FAIL sb_readback: v=%b d=%h want 1 8877abf5",
                  bus.rsp_valid, bus.rsp_data);
      end
   endtask

   task automatic test_misaligned();
      logic [AW-1:0] ma [3] = '{12'h013, 12'h011, 12'h010};
      logic [1:0]    ms [3] = '{2'd2, 2'd1, 2'd3};
      logic          mw [3] = '{1'b0, 1'b1, 1'b0};
      int rd0;
      int wen0;
      rd0 = n_rd;
      wen0 = n_wen;
      for (int i = 0; i < 3; i++) begin
         drive(mw[i], ms[i], 1'b0, ma[i], 32'h00001234, TW'(i + 7));
         #1;
         n_cmp++;
         if (dccm_rvalid_in !== 1'b0 || dccm_wen !== 1'b0) begin
            n_bad++;
            $display("FAIL mis%0d_access: rd=%b wen=%b want 0/0",
                     i, dccm_rvalid_in, dccm_wen);
         end
         nxt();
         bus.req_valid = 1'b0;
         n_cmp++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 ||
             bus.rsp_data !== 32'h0 || bus.rsp_tag !== TW'(i + 7) ||
             bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mis%0d_rsp: v=%b e=%b d=%h t=%0d rdy=%b want 1 1 0 %0d 1",
                     i, bus.rsp_valid, bus.rsp_err, bus.rsp_data,
                     bus.rsp_tag, bus.req_ready, i + 7);
         end
      end
      nxt();
      n_cmp++;
      if (n_rd != rd0 || n_wen != wen0) begin
         n_bad++;
         $display("FAIL mis_counts: reads=%0d writes=%0d want %0d %0d",
                  n_rd, n_wen, rd0, wen0);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 2'd2, 1'b0, 12'h010, 32'h11223344, 4'd1);
      #1;
      n_cmp++;
      if (dccm_wen !== 1'b1 || dccm_waddr !== 10'd4 ||
          dccm_wdata !== 32'h11223344 || dccm_rvalid_in !== 1'b0) begin
         n_bad++;
         $display("FAIL sw_write: wen=%b waddr=%0d wdata=%h rd=%b want 1/4/11223344/0",
                  dccm_wen, dccm_waddr, dccm_wdata, dccm_rvalid_in);
      end
      nxt();
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'd1 || bus.rsp_err !== 1'b0 ||
          bus.rsp_data !== 32'h0 || bus.req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL sw_rsp: v=%b t=%0d e=%b d=%h rdy=%b want 1 1 0 0 1",
                  bus.rsp_valid, bus.rsp_tag, bus.rsp_err, bus.rsp_data, bus.req_ready);
      end
      drive(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 4'd2);
      #1;
      n_cmp++;
      if (dccm_rvalid_in !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_strobe: rd=%b want 1", dccm_rvalid_in);
      end
      nxt();
      bus.req_valid = 1'b0;
      n_cmp++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_wait: v=%b rdy=%b want 0 0", bus.rsp_valid, bus.req_ready);
      end
      nxt();
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h11223344 || bus.rsp_tag !== 4'd2) begin
         n_bad++;
         $display("FAIL b2b_rsp: v=%b d=%h t=%0d want 1 11223344 2",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_tag);
      end
   endtask

   task automatic test_reset_midflight();
      int seen;
      drive(1'b0, 2'd0, 1'b0, 12'h010, 32'h0, 4'd9);
      nxt();
      bus.req_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (dccm_rvalid_in !== 1'b0 || dccm_wen !== 1'b0 || dccm_raddr !== '0 ||
          bus.rsp_valid !== 1'b0 || bus.rsp_tag !== '0 || bus.rsp_data !== '0) begin
         n_bad++;
         $display("FAIL rst_flight: rd=%b wen=%b raddr=%0d v=%b t=%0d d=%h want all 0",
                  dccm_rvalid_in, dccm_wen, dccm_raddr, bus.rsp_valid,
                  bus.rsp_tag, bus.rsp_data);
      end
      nxt();
      rst = 1'b0;
      rv_extra = 1'b1;
      #1;
      n_cmp++;
      if (bus.req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_ready: got %b want 1", bus.req_ready);
      end
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         nxt();
         rv_extra = 1'b0;
         if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_bad++;
         $display("FAIL rst_stale: %0d bad cycles want 0", seen);
      end
      drive(1'b0, 2'd1, 1'b1, 12'h012, 32'h0, 4'd4);
      nxt();
      bus.req_valid = 1'b0;
      nxt();
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h00001122 || bus.rsp_tag !== 4'd4) begin
         n_bad++;
         $display("FAIL rst_after: v=%b d=%h t=%0d want 1 00001122 4",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_tag);
      end
   endtask

   initial begin
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;
      bus.req_tag      = '0;
      test_reset();
      test_loads();
      test_sb_rmw();
      test_misaligned();
      test_back_to_back();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
